// File: rtl/multi_switch_debouncer.sv
// rtl/multi_switch_debouncer.sv - N-channel switch debouncer with shared prescaler; macro SWITCH_DEBOUNCE_EDGE_PULSE_EN enables edge pulses
module multi_switch_debouncer #(
    parameter int              N_CH         = 4,
    parameter int              STABLE_COUNT = 1000000,
    parameter int              PRESCALE     = 1,
    parameter logic [N_CH-1:0] INIT_LEVEL   = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sw_in,
    output logic [N_CH-1:0] sw_db,
    output logic [N_CH-1:0] sw_rise,
    output logic [N_CH-1:0] sw_fall,
    output logic            any_change
);

    localparam int CW = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_COUNT - 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [N_CH-1:0] s1_q, s1_d;
    logic [N_CH-1:0] s2_q, s2_d;
    logic [N_CH-1:0] db_q, db_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [CW-1:0]   cnt_q [N_CH];
    logic [CW-1:0]   cnt_d [N_CH];
    logic            tick;

    always_comb begin
        s1_d  = sw_in;
        s2_d  = s1_q;
        tick  = (pre_q == PRE_MAX);
        pre_d = tick ? '0 : pre_q + PW'(1);
        db_d  = db_q;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            // Any sample matching the output restarts the count, tick or not.
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] >= CNT_MAX) begin
                    db_d[i]  = s2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q  <= INIT_LEVEL;
            s2_q  <= INIT_LEVEL;
            db_q  <= INIT_LEVEL;
            pre_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            db_q  <= db_d;
            pre_q <= pre_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_db = db_q;

`ifdef SWITCH_DEBOUNCE_EDGE_PULSE_EN
    logic [N_CH-1:0] rise_q, rise_d;
    logic [N_CH-1:0] fall_q, fall_d;
    logic            any_q, any_d;

    // Pulses are registered from the next-state so they line up with the new sw_db.
    always_comb begin
        rise_d = db_d & ~db_q;
        fall_d = ~db_d & db_q;
        any_d  = |(db_d ^ db_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rise_q <= '0;
            fall_q <= '0;
            any_q  <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
            any_q  <= any_d;
        end
    end

    assign sw_rise    = rise_q;
    assign sw_fall    = fall_q;
    assign any_change = any_q;
`else
    assign sw_rise    = '0;
    assign sw_fall    = '0;
    assign any_change = 1'b0;
`endif

endmodule

// File: tb/tb_multi_switch_debouncer.sv
// tb/tb_multi_switch_debouncer.sv - directed self-checking bench for multi_switch_debouncer
module tb_multi_switch_debouncer;

`ifdef SWITCH_DEBOUNCE_EDGE_PULSE_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] sw_in, sw_in_p;
    logic [3:0] sw_db, sw_rise, sw_fall;
    logic       any_change;
    logic [3:0] db_p, rise_p, fall_p;
    logic       any_p;

    int vectors;
    int miscompares;

    multi_switch_debouncer #(
        .N_CH(4), .STABLE_COUNT(8), .PRESCALE(1), .INIT_LEVEL(4'b0000)
    ) dut (
        .clk(clk), .rst(rst), .sw_in(sw_in), .sw_db(sw_db),
        .sw_rise(sw_rise), .sw_fall(sw_fall), .any_change(any_change)
    );

    multi_switch_debouncer #(
        .N_CH(4), .STABLE_COUNT(3), .PRESCALE(4), .INIT_LEVEL(4'b0000)
    ) dut_p (
        .clk(clk), .rst(rst), .sw_in(sw_in_p), .sw_db(db_p),
        .sw_rise(rise_p), .sw_fall(fall_p), .any_change(any_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        sw_in = 4'b0000;
        sw_in_p = 4'b0000;
        tick();
        tick();
        vectors++;
        if ({sw_db, sw_rise, sw_fall, any_change} !== 13'b0) begin
            miscompares++;
            $display("FAIL reset_main: db=%b rise=%b fall=%b any=%b, required all zero", sw_db, sw_rise, sw_fall, any_change);
        end
        vectors++;
        if ({db_p, rise_p, fall_p, any_p} !== 13'b0) begin
            miscompares++;
            $display("FAIL reset_presc: db=%b rise=%b fall=%b any=%b, required all zero", db_p, rise_p, fall_p, any_p);
        end
    endtask

    // Prescaled instance: released from reset together with the new input level.
    task automatic test_prescale();
        int first;
        first = -1;
        sw_in_p = 4'b0001;
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (first < 0 && db_p[0] === 1'b1) begin
                first = k;
                vectors++;
                if (rise_p !== (PE ? 4'b0001 : 4'b0000) || any_p !== PE) begin
                    miscompares++;
                    $display("FAIL presc_pulse: rise=%b any=%b, required rise=%b any=%b", rise_p, any_p, PE ? 4'b0001 : 4'b0000, PE);
                end
            end else if (first >= 0 && k == first + 1) begin
                vectors++;
                if (rise_p !== 4'b0000 || any_p !== 1'b0) begin
                    miscompares++;
                    $display("FAIL presc_pulse_end: rise=%b any=%b, required 0000 0", rise_p, any_p);
                end
            end
        end
        vectors++;
        if (first < 9 || first > 14) begin
            miscompares++;
            $display("FAIL presc_latency: db changed at edge %0d, required 9..14", first);
        end
    endtask

    task automatic test_step();
        sw_in = 4'b0001;
        for (int k = 0; k < 9; k++) begin
            tick();
            vectors++;
            if (sw_db !== 4'b0000 || sw_rise !== 4'b0000 || any_change !== 1'b0) begin
                miscompares++;
                $display("FAIL step_early e%0d: db=%b rise=%b any=%b, required 0000 0000 0", k, sw_db, sw_rise, any_change);
            end
        end
        tick();
        vectors++;
        if (sw_db !== 4'b0001 || sw_rise !== (PE ? 4'b0001 : 4'b0000) || sw_fall !== 4'b0000 || any_change !== PE) begin
            miscompares++;
            $display("FAIL step_update: db=%b rise=%b fall=%b any=%b, required 0001 %b 0000 %b", sw_db, sw_rise, sw_fall, any_change, PE ? 4'b0001 : 4'b0000, PE);
        end
        tick();
        vectors++;
        if (sw_db !== 4'b0001 || sw_rise !== 4'b0000 || any_change !== 1'b0) begin
            miscompares++;
            $display("FAIL step_after: db=%b rise=%b any=%b, required 0001 0000 0", sw_db, sw_rise, any_change);
        end
    endtask

    task automatic test_glitch();
        sw_in = 4'b0011;
        repeat (5) tick();
        sw_in = 4'b0001;
        for (int k = 0; k < 15; k++) begin
            tick();
            vectors++;
            if ({sw_db, sw_rise, sw_fall, any_change} !== {4'b0001, 4'b0000, 4'b0000, 1'b0}) begin
                miscompares++;
                $display("FAIL glitch_ignored t%0d: db=%b rise=%b fall=%b any=%b, required 0001 0000 0000 0", k, sw_db, sw_rise, sw_fall, any_change);
            end
        end
        sw_in = 4'b0011;
        repeat (3) tick();
        sw_in = 4'b0001;
        repeat (2) tick();
        sw_in = 4'b0011;
        for (int k = 0; k < 9; k++) begin
            tick();
            vectors++;
            if (sw_db !== 4'b0001 || sw_rise !== 4'b0000) begin
                miscompares++;
                $display("FAIL bounce_early e%0d: db=%b rise=%b, required 0001 0000", k, sw_db, sw_rise);
            end
        end
        tick();
        vectors++;
        if (sw_db !== 4'b0011 || sw_rise !== (PE ? 4'b0010 : 4'b0000) || any_change !== PE) begin
            miscompares++;
            $display("FAIL bounce_update: db=%b rise=%b any=%b, required 0011 %b %b", sw_db, sw_rise, any_change, PE ? 4'b0010 : 4'b0000, PE);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] ins  [3];
        logic [3:0] prev [3];
        logic [3:0] er, ef;
        ins[0] = 4'b0000; prev[0] = 4'b0011;
        ins[1] = 4'b1010; prev[1] = 4'b0000;
        ins[2] = 4'b0000; prev[2] = 4'b1010;
        for (int v = 0; v < 3; v++) begin
            er = PE ? (ins[v] & ~prev[v]) : 4'b0000;
            ef = PE ? (~ins[v] & prev[v]) : 4'b0000;
            sw_in = ins[v];
            for (int k = 0; k < 9; k++) begin
                tick();
                vectors++;
                if (sw_db !== prev[v] || sw_rise !== 4'b0000 || sw_fall !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL simul_early v%0d e%0d: db=%b rise=%b fall=%b, required %b 0000 0000", v, k, sw_db, sw_rise, sw_fall, prev[v]);
                end
            end
            tick();
            vectors++;
            if (sw_db !== ins[v] || sw_rise !== er || sw_fall !== ef || any_change !== PE) begin
                miscompares++;
                $display("FAIL simul_update v%0d: db=%b rise=%b fall=%b any=%b, required %b %b %b %b", v, sw_db, sw_rise, sw_fall, any_change, ins[v], er, ef, PE);
            end
            tick();
            vectors++;
            if (sw_rise !== 4'b0000 || sw_fall !== 4'b0000 || any_change !== 1'b0) begin
                miscompares++;
                $display("FAIL simul_after v%0d: rise=%b fall=%b any=%b, required 0000 0000 0", v, sw_rise, sw_fall, any_change);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        sw_in = 4'b0100;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        vectors++;
        if ({sw_db, sw_rise, sw_fall, any_change} !== 13'b0) begin
            miscompares++;
            $display("FAIL midreset_state: db=%b rise=%b fall=%b any=%b, required all zero", sw_db, sw_rise, sw_fall, any_change);
        end
        rst = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            vectors++;
            if (sw_db !== 4'b0000 || sw_rise !== 4'b0000) begin
                miscompares++;
                $display("FAIL midreset_early e%0d: db=%b rise=%b, required 0000 0000", k, sw_db, sw_rise);
            end
        end
        tick();
        vectors++;
        if (sw_db !== 4'b0100 || sw_rise !== (PE ? 4'b0100 : 4'b0000) || any_change !== PE) begin
            miscompares++;
            $display("FAIL midreset_update: db=%b rise=%b any=%b, required 0100 %b %b", sw_db, sw_rise, any_change, PE ? 4'b0100 : 4'b0000, PE);
        end
        tick();
        vectors++;
        if (sw_db !== 4'b0100 || sw_rise !== 4'b0000 || any_change !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_after: db=%b rise=%b any=%b, required 0100 0000 0", sw_db, sw_rise, any_change);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        sw_in = 4'b0000;
        sw_in_p = 4'b0000;
        test_reset();
        test_prescale();
        test_step();
        test_glitch();
        test_simultaneous();
        test_reset_mid_count();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
